axi_read_arbiter: RTL and testbench

//  Shares one AXI4 master read channel (AR + R) among NREQ local requesters.

---
 rtl/axi_rd_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/axi_read_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arb_pkg.sv
// Shared types and widths for the AXI read-channel arbiter.
package axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int BEAT_CNT_W  = 9;

    // Requester index following idx, wrapping at n.
    function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational masked-priority pick: lowest requester at or above ptr wins,
// otherwise the lowest requester overall.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    logic [N-1:0] mask;
    logic [N-1:0] masked_req;
    logic [N-1:0] pick_vec;

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign mask[gi] = (ptr <= IW'(gi));
    end

    assign masked_req = req & mask;
    assign pick_vec   = (|masked_req) ? masked_req : req;
    assign grant_any  = |req;

    // Descending scan so the lowest set bit is the one that sticks.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick_vec[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read channel among NREQ requesters, one burst in flight.
// Define RD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module axi_read_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int AW   = 32,
    parameter  int DW   = 64,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NREQ*AW-1:0]            req_araddr,
    input  logic [NREQ*AXI_LEN_W-1:0]     req_arlen,
    input  logic [NREQ*AXI_SIZE_W-1:0]    req_arsize,
    input  logic [NREQ*AXI_BURST_W-1:0]   req_arburst,
    input  logic [NREQ-1:0]               req_arvalid,
    output logic [NREQ-1:0]               req_arready,
    output logic [DW-1:0]                 req_rdata,
    output logic                          req_rlast,
    output logic [NREQ-1:0]               req_rvalid,
    input  logic [NREQ-1:0]               req_rready,
    output logic [AW-1:0]                 m_axi_araddr,
    output logic [AXI_LEN_W-1:0]          m_axi_arlen,
    output logic [AXI_SIZE_W-1:0]         m_axi_arsize,
    output logic [AXI_BURST_W-1:0]        m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [DW-1:0]                 m_axi_rdata,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          rlast_err
);

    state_e                  state_reg, state_next;
    logic [IW-1:0]           grant_id_reg, grant_id_next;
    logic [IW-1:0]           rr_ptr_reg, rr_ptr_next;
    logic [BEAT_CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic                    rlast_err_reg, rlast_err_next;
    logic                    load_ar;

    logic [AW-1:0]           araddr_reg;
    logic [AXI_LEN_W-1:0]    arlen_reg;
    logic [AXI_SIZE_W-1:0]   arsize_reg;
    logic [AXI_BURST_W-1:0]  arburst_reg;

    logic [AW-1:0]           araddr_arr  [NREQ];
    logic [AXI_LEN_W-1:0]    arlen_arr   [NREQ];
    logic [AXI_SIZE_W-1:0]   arsize_arr  [NREQ];
    logic [AXI_BURST_W-1:0]  arburst_arr [NREQ];

    logic [NREQ-1:0]         win_onehot;
    logic [IW-1:0]           win_idx;
    logic                    win_any;
    logic [IW-1:0]           ptr_after_win;

    logic                    in_data;
    logic                    owner_rready;
    logic                    beat;
    logic                    final_beat;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign araddr_arr[gi]  = req_araddr[gi*AW +: AW];
        assign arlen_arr[gi]   = req_arlen[gi*AXI_LEN_W +: AXI_LEN_W];
        assign arsize_arr[gi]  = req_arsize[gi*AXI_SIZE_W +: AXI_SIZE_W];
        assign arburst_arr[gi] = req_arburst[gi*AXI_BURST_W +: AXI_BURST_W];
    end

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req       (req_arvalid),
        .ptr       (rr_ptr_reg),
        .grant     (win_onehot),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

`ifdef RD_ARB_FIXED_PRIO_EN
    assign ptr_after_win = '0;
`else
    assign ptr_after_win = IW'(wrap_next(32'(win_idx), NREQ));
`endif

    // R steering: only the owner sees rvalid, and only the owner's rready reaches the master.
    assign in_data       = (state_reg == DATA);
    assign owner_rready  = req_rready[grant_id_reg];
    assign m_axi_rready  = in_data & owner_rready;
    assign beat          = in_data & m_axi_rvalid & owner_rready;
    assign final_beat    = (beat_cnt_reg == BEAT_CNT_W'(arlen_reg));
    assign req_rdata     = in_data ? m_axi_rdata : '0;
    assign req_rlast     = in_data & m_axi_rlast;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rvalid
        assign req_rvalid[gi] = in_data & m_axi_rvalid & (grant_id_reg == IW'(gi));
    end

    always_comb begin
        state_next     = state_reg;
        grant_id_next  = grant_id_reg;
        rr_ptr_next    = rr_ptr_reg;
        beat_cnt_next  = beat_cnt_reg;
        rlast_err_next = rlast_err_reg;
        load_ar        = 1'b0;
        req_arready    = '0;
        m_axi_arvalid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win_any) begin
                    req_arready   = win_onehot;
                    load_ar       = 1'b1;
                    grant_id_next = win_idx;
                    rr_ptr_next   = ptr_after_win;
                    state_next    = ADDR;
                end
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    beat_cnt_next = '0;
                    state_next    = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    beat_cnt_next = beat_cnt_reg + BEAT_CNT_W'(1);
                    // Flag rlast that arrives early, or a final beat that lacks it.
                    if (m_axi_rlast != final_beat && (m_axi_rlast || final_beat)) begin
                        rlast_err_next = 1'b1;
                    end
                    if (m_axi_rlast) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            grant_id_reg  <= '0;
            rr_ptr_reg    <= '0;
            beat_cnt_reg  <= '0;
            rlast_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_id_reg  <= grant_id_next;
            rr_ptr_reg    <= rr_ptr_next;
            beat_cnt_reg  <= beat_cnt_next;
            rlast_err_reg <= rlast_err_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            araddr_reg  <= '0;
            arlen_reg   <= '0;
            arsize_reg  <= '0;
            arburst_reg <= '0;
        end else if (load_ar) begin
            araddr_reg  <= araddr_arr[win_idx];
            arlen_reg   <= arlen_arr[win_idx];
            arsize_reg  <= arsize_arr[win_idx];
            arburst_reg <= arburst_arr[win_idx];
        end
    end

    assign m_axi_araddr  = araddr_reg;
    assign m_axi_arlen   = arlen_reg;
    assign m_axi_arsize  = arsize_reg;
    assign m_axi_arburst = arburst_reg;
    assign grant_id      = grant_id_reg;
    assign busy          = (state_reg != IDLE);
    assign rlast_err     = rlast_err_reg;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: random requesters and master against a
// transaction-level model of the arbitration and burst rules.
module tb_axi_read_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int IW   = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic [NREQ*AW-1:0]   req_araddr;
    logic [NREQ*8-1:0]    req_arlen;
    logic [NREQ*3-1:0]    req_arsize;
    logic [NREQ*2-1:0]    req_arburst;
    logic [NREQ-1:0]      req_arvalid;
    logic [NREQ-1:0]      req_arready;
    logic [DW-1:0]        req_rdata;
    logic                 req_rlast;
    logic [NREQ-1:0]      req_rvalid;
    logic [NREQ-1:0]      req_rready;
    logic [AW-1:0]        m_axi_araddr;
    logic [7:0]           m_axi_arlen;
    logic [2:0]           m_axi_arsize;
    logic [1:0]           m_axi_arburst;
    logic                 m_axi_arvalid;
    logic                 m_axi_arready;
    logic [DW-1:0]        m_axi_rdata;
    logic                 m_axi_rlast;
    logic                 m_axi_rvalid;
    logic                 m_axi_rready;
    logic [IW-1:0]        grant_id;
    logic                 busy;
    logic                 rlast_err;

    always #5 clk = ~clk;

    axi_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .resetn(resetn),
        .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arsize(req_arsize),
        .req_arburst(req_arburst), .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_rdata(req_rdata), .req_rlast(req_rlast), .req_rvalid(req_rvalid),
        .req_rready(req_rready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .grant_id(grant_id), .busy(busy), .rlast_err(rlast_err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } ar_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    ar_t   req_q [NREQ][$];
    beat_t r_q[$];
    int    grant_log[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Stimulus knobs
    int    ar_rdy_mode   = 1;   // 0 random, 1 always ready, 2 never ready
    int    rready_mode   = 1;   // 0 random, 1 always ready
    bit    err_en        = 1'b0;
    bit    drop_en       = 1'b0;
    int    plan_override = -1;

    // Master-side burst progress
    bit    have      = 1'b0;
    int    bidx      = 0;
    int    last_beat = 0;
    int    blen      = 0;

    // Reference model state
    int    m_phase = 0;         // 0 idle, 1 address, 2 data
    int    m_ptr   = 0;
    int    m_owner = 0;
    int    m_beats = 0;
    bit    m_err   = 1'b0;
    ar_t   cur_ar;
    int    beats_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
        int p;
        p = ptr;
`ifdef RD_ARB_FIXED_PRIO_EN
        p = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic ar_t mk_ar(input logic [AW-1:0] addr, input logic [7:0] len);
        ar_t a;
        a.addr  = addr;
        a.len   = len;
        a.size  = 3'd3;
        a.burst = 2'd1;
        return a;
    endfunction

    function automatic ar_t rand_ar(input int maxlen);
        ar_t a;
        a.addr  = $urandom;
        a.len   = 8'($urandom_range(maxlen));
        a.size  = 3'($urandom_range(3));
        a.burst = 2'($urandom_range(2));
        return a;
    endfunction

    task automatic drive_idle();
        req_araddr    = '0;
        req_arlen     = '0;
        req_arsize    = '0;
        req_arburst   = '0;
        req_arvalid   = '0;
        req_rready    = '0;
        m_axi_arready = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;
    endtask

    // Driver: requesters hold each request until accepted; master answers bursts.
    initial begin : driver
        logic [NREQ-1:0] acc;
        logic [7:0]      hs_len;
        bit              ar_hs;
        bit              r_hs;
        ar_t             a;
        drive_idle();
        forever begin
            @(negedge clk);
            acc    = req_arvalid & req_arready;
            ar_hs  = m_axi_arvalid & m_axi_arready;
            r_hs   = m_axi_rvalid & m_axi_rready;
            hs_len = m_axi_arlen;
            @(posedge clk);
            #1;
            if (!resetn) begin
                for (int i = 0; i < NREQ; i++) req_q[i].delete();
                r_q.delete();
                have = 1'b0;
                bidx = 0;
                drive_idle();
                continue;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !req_arvalid[i]) begin
                    if (req_q[i].size() > 0) begin
                        a = req_q[i].pop_front();
                        req_araddr[i*AW +: AW] = a.addr;
                        req_arlen[i*8 +: 8]    = a.len;
                        req_arsize[i*3 +: 3]   = a.size;
                        req_arburst[i*2 +: 2]  = a.burst;
                        req_arvalid[i]         = 1'b1;
                    end else begin
                        req_arvalid[i] = 1'b0;
                    end
                end else if (drop_en && $urandom_range(15) == 0) begin
                    req_arvalid[i] = 1'b0;
                end
            end
            case (ar_rdy_mode)
                1:       m_axi_arready = 1'b1;
                2:       m_axi_arready = 1'b0;
                default: m_axi_arready = 1'($urandom_range(1));
            endcase
            if (ar_hs) begin
                have = 1'b1;
                bidx = 0;
                blen = int'(hs_len);
                if (plan_override >= 0) last_beat = plan_override;
                else if (err_en && $urandom_range(7) == 0)
                    last_beat = (blen > 0 && $urandom_range(1) == 0) ? int'($urandom_range(blen - 1)) : blen + 1;
                else last_beat = blen;
            end
            if (r_hs) begin
                bidx++;
                m_axi_rvalid = 1'b0;
                m_axi_rlast  = 1'b0;
                if (bidx > last_beat) have = 1'b0;
            end
            if (have && !m_axi_rvalid && $urandom_range(3) != 0) begin
                m_axi_rdata  = {$urandom, $urandom};
                m_axi_rlast  = (bidx == last_beat);
                m_axi_rvalid = 1'b1;
                r_q.push_back({m_axi_rdata, m_axi_rlast});
            end
            req_rready = (rready_mode == 1) ? '1 : NREQ'($urandom);
        end
    end

    // Monitor: compare DUT against the model, then advance the model past this edge.
    always @(negedge clk) begin : monitor
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rv;
        beat_t           b;
        int              w;
        if (!resetn) begin
            m_phase = 0; m_ptr = 0; m_owner = 0; m_beats = 0; m_err = 1'b0;
            beats_seen = 0;
            grant_log.delete();
        end else begin
            exp_rdy = '0;
            w = -1;
            if (m_phase == 0) begin
                w = model_pick(req_arvalid, m_ptr);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            exp_rv = '0;
            if (m_phase == 2 && m_axi_rvalid) exp_rv[m_owner] = 1'b1;
            chk("arready", 64'(req_arready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(m_phase != 0));
            chk("m_arvalid", 64'(m_axi_arvalid), 64'(m_phase == 1));
            chk("rlast_err", 64'(rlast_err), 64'(m_err));
            chk("rvalid", 64'(req_rvalid), 64'(exp_rv));
            if (m_phase != 0) chk("grant_id", 64'(grant_id), 64'(m_owner));
            if (m_phase == 1)
                chk("ar_payload", 64'({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst}), 64'(cur_ar));
            if (m_phase == 2) chk("m_rready", 64'(m_axi_rready), 64'(req_rready[m_owner]));
            if (|(req_rvalid & req_rready)) begin
                if (r_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat: got an R handshake, expected none pending");
                end else begin
                    b = r_q.pop_front();
                    chk("rdata", 64'(req_rdata), 64'(b.data));
                    chk("rlast", 64'(req_rlast), 64'(b.last));
                    beats_seen++;
                end
            end
            case (m_phase)
                0: if (w >= 0) begin
                    cur_ar = {req_araddr[w*AW +: AW], req_arlen[w*8 +: 8],
                              req_arsize[w*3 +: 3], req_arburst[w*2 +: 2]};
                    grant_log.push_back(w);
                    m_owner = w;
                    m_ptr   = (w + 1) % NREQ;
                    m_phase = 1;
                    $display("[TB] grant req%0d addr=%08h len=%0d", w, cur_ar.addr, cur_ar.len);
                end
                1: if (m_axi_arready) begin
                    m_phase = 2;
                    m_beats = 0;
                end
                default: if (m_axi_rvalid && req_rready[m_owner]) begin
                    if (m_axi_rlast && m_beats != int'(cur_ar.len)) m_err = 1'b1;
                    if (!m_axi_rlast && m_beats == int'(cur_ar.len)) m_err = 1'b1;
                    m_beats++;
                    if (m_axi_rlast) m_phase = 0;
                end
            endcase
        end
    end

    task automatic wait_idle(input int budget);
        int  c;
        bit  done;
        c = 0;
        done = 1'b0;
        while (!done && c < budget) begin
            @(negedge clk);
            done = (m_phase == 0) && (req_arvalid == '0) && (r_q.size() == 0) && !have;
            for (int i = 0; i < NREQ; i++) if (req_q[i].size() != 0) done = 1'b0;
            c++;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles", budget);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_arready"}, 64'(req_arready), 64'(0));
        chk({tag, "_arvalid"}, 64'(m_axi_arvalid), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_grant_id"}, 64'(grant_id), 64'(0));
        chk({tag, "_rlast_err"}, 64'(rlast_err), 64'(0));
        chk({tag, "_rvalid"}, 64'(req_rvalid), 64'(0));
        chk({tag, "_m_rready"}, 64'(m_axi_rready), 64'(0));
        chk({tag, "_araddr"}, 64'(m_axi_araddr), 64'(0));
        chk({tag, "_arlen"}, 64'(m_axi_arlen), 64'(0));
        chk({tag, "_rdata"}, 64'(req_rdata), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        #1 resetn = 1'b1;
    endtask

    initial begin : main
        int exp_order[5];
        int b0;
        int c;
`ifdef RD_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        repeat (3) @(negedge clk);
        chk_outputs_zero("por");
        #1 resetn = 1'b1;

        // Single burst from requester 0
        req_q[0].push_back(mk_ar(32'h0000_1000, 8'd3));
        wait_idle(200);
        chk("t1_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(0));
        chk("t1_beats", 64'(beats_seen), 64'(4));
        chk("t1_err", 64'(rlast_err), 64'(0));

        // All requesters busy: grant order
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            for (int k = 0; k < (i == 0 ? 5 : 2); k++)
                req_q[i].push_back(mk_ar(32'(i * 32'h100 + k * 4), 8'd0));
        end
        wait_idle(600);
        for (int k = 0; k < 5; k++)
            chk("t2_order", 64'(grant_log.size() > k ? grant_log[k] : -1), 64'(exp_order[k]));

        // Master holds AR not ready
        ar_rdy_mode = 2;
        req_q[2].push_back(mk_ar(32'h2000_0040, 8'd1));
        c = 0;
        while (!m_axi_arvalid && c < 20) begin
            @(negedge clk);
            c++;
        end
        repeat (5) @(negedge clk);
        chk("t3_arvalid_held", 64'(m_axi_arvalid), 64'(1));
        chk("t3_araddr_held", 64'(m_axi_araddr), 64'(32'h2000_0040));
        ar_rdy_mode = 1;
        wait_idle(200);

        // Owner rready toggling
        rready_mode = 0;
        b0 = beats_seen;
        req_q[3].push_back(mk_ar(32'h3000_0000, 8'd7));
        wait_idle(400);
        chk("t4_beats", 64'(beats_seen - b0), 64'(8));
        rready_mode = 1;

        // Early rlast, then missing rlast
        plan_override = 2;
        b0 = beats_seen;
        req_q[1].push_back(mk_ar(32'h4000_0000, 8'd3));
        wait_idle(200);
        chk("t5_early_err", 64'(rlast_err), 64'(1));
        chk("t5_early_beats", 64'(beats_seen - b0), 64'(3));
        do_reset();
        req_q[1].push_back(mk_ar(32'h4000_0100, 8'd1));
        wait_idle(200);
        chk("t5_late_err", 64'(rlast_err), 64'(1));
        chk("t5_late_beats", 64'(beats_seen), 64'(3));
        plan_override = -1;

        // Reset in the middle of a burst
        do_reset();
        req_q[0].push_back(mk_ar(32'h5000_0000, 8'd7));
        c = 0;
        while (!(have && bidx == 2) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("t6_reached_beat2", 64'(bidx), 64'(2));
        #1 resetn = 1'b0;
        #1 chk_outputs_zero("t6_midburst");
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        req_q[1].push_back(mk_ar(32'h6000_0000, 8'd0));
        wait_idle(200);
        chk("t6_regrant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(1));

        // Longest burst
        b0 = beats_seen;
        req_q[3].push_back(mk_ar(32'h7000_0000, 8'd255));
        wait_idle(1500);
        chk("t7_beats", 64'(beats_seen - b0), 64'(256));
        chk("t7_err", 64'(rlast_err), 64'(0));

        // Random traffic
        ar_rdy_mode = 0;
        rready_mode = 0;
        err_en      = 1'b1;
        drop_en     = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0)
                req_q[$urandom_range(NREQ - 1)].push_back(rand_ar($urandom_range(7) == 0 ? 15 : 3));
            @(negedge clk);
        end
        drop_en = 1'b0;
        wait_idle(5000);
        chk("final_r_q_empty", 64'(r_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
